// File: rtl/bram_read_arbiter_if.sv
// Requester and RAM-port signal bundle for bram_read_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/RAM side.
interface bram_read_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              req1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_en;
   logic              ram_regce;
   logic [DATA_W-1:0] ram_dout;

   modport slave (
      input  req0, req1, addr0, addr1, ram_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_en, ram_regce
   );

   modport master (
      output req0, req1, addr0, addr1, ram_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_en, ram_regce
   );
endinterface

// File: rtl/bram_read_arbiter.sv
// Two-requester read arbiter for a block RAM with a 1- or 2-cycle read latency.
// Optional starvation guard for requester 1 is enabled by defining BRAM_ARB_STARVE_GUARD_EN.
module bram_read_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 16,
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 7
) (
   input  logic               clka,
   input  logic               rsta_n,
   bram_read_arbiter_if.slave bus
);
   localparam int NSTG = LATENCY + 1;

   logic              grant0;
   logic              grant1;
   logic              prio1;
   logic [NSTG-1:0]   tag_v;
   logic [NSTG-1:0]   tag_id;
   logic [ADDR_W-1:0] addr_q;

`ifdef BRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             promote_q;

   // Once the counter sits at STARVE_MAX for a denied cycle, req1 owns the next arbitration.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         starve_cnt <= '0;
         promote_q  <= 1'b0;
      end else if (!bus.req1 || grant1) begin
         starve_cnt <= '0;
         promote_q  <= 1'b0;
      end else begin
         if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
         if (starve_cnt == CNT_W'(STARVE_MAX)) promote_q <= 1'b1;
      end
   end

   assign prio1 = promote_q;
`else
   // Strict req0 priority; the comparison is always false for any legal STARVE_MAX.
   assign prio1 = (STARVE_MAX < 0);
`endif

   // Handshake: a requester holds reqN with addrN stable; the read is accepted on the
   // rising edge where gntN is high, and its data returns with rvalidN LATENCY+1 cycles later.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rsta_n) begin
         if (bus.req1 && (prio1 || !bus.req0)) begin
            grant1 = 1'b1;
         end else if (bus.req0) begin
            grant0 = 1'b1;
         end
      end
   end

   // Stage 0 lines up with ram_en; stage LATENCY lines up with valid RAM output.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         tag_v  <= '0;
         tag_id <= '0;
         addr_q <= '0;
      end else begin
         tag_v  <= {tag_v[NSTG-2:0], grant0 | grant1};
         tag_id <= {tag_id[NSTG-2:0], grant1};
         if (grant0) begin
            addr_q <= bus.addr0;
         end else if (grant1) begin
            addr_q <= bus.addr1;
         end
      end
   end

   if (LATENCY == 2) begin : g_regce
      assign bus.ram_regce = tag_v[1];
   end else begin : g_no_regce
      assign bus.ram_regce = 1'b0;
   end

   assign bus.gnt0     = grant0;
   assign bus.gnt1     = grant1;
   assign bus.ram_en   = tag_v[0];
   assign bus.ram_addr = addr_q;
   assign bus.rvalid0  = tag_v[LATENCY] & ~tag_id[LATENCY];
   assign bus.rvalid1  = tag_v[LATENCY] &  tag_id[LATENCY];
   assign bus.rdata    = bus.ram_dout;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: a LATENCY=2 instance with a scoreboard and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_bram_read_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  // clock / reset
  logic clka = 1'b0;
  logic rsta_n = 1'b0;
  always #5 clka = ~clka;

  bram_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();
  bram_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  bram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2), .STARVE_MAX(7)) dut (
    .clka   (clka),
    .rsta_n (rsta_n),
    .bus    (bus2)
  );

  bram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1), .STARVE_MAX(7)) dut_l1 (
    .clka   (clka),
    .rsta_n (rsta_n),
    .bus    (bus1)
  );

  // RAM models: 2-cycle with output register enable, and 1-cycle
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram2_q, ram2_dout, ram1_dout;
  always @(posedge clka) begin
    if (bus2.ram_en) ram2_q <= mem[bus2.ram_addr];
    if (bus2.ram_regce) ram2_dout <= ram2_q;
    if (bus1.ram_en) ram1_dout <= mem[bus1.ram_addr];
  end
  assign bus2.ram_dout = ram2_dout;
  assign bus1.ram_dout = ram1_dout;

  // checking
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard on the LATENCY=2 instance: {id, data} in issue order
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] sb_e;
  int rv0_run, rv0_max, rv0_total;
  always @(negedge clka) begin
    if (!rsta_n) begin
      exp_q.delete();
    end else begin
      if (bus2.rvalid0 || bus2.rvalid1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_rid", {31'd0, bus2.rvalid1}, {31'd0, sb_e[DATA_W]});
          check("sb_rdata", {16'd0, bus2.rdata}, {16'd0, sb_e[DATA_W-1:0]});
        end
      end
      if (bus2.rvalid0) begin
        rv0_run++;
        rv0_total++;
        if (rv0_run > rv0_max) rv0_max = rv0_run;
      end else begin
        rv0_run = 0;
      end
      if (bus2.gnt0) exp_q.push_back({1'b0, mem[bus2.addr0]});
      else if (bus2.gnt1) exp_q.push_back({1'b1, mem[bus2.addr1]});
    end
  end

  // driver tasks
  task automatic drive2(input logic r0, input logic [ADDR_W-1:0] a0,
                        input logic r1, input logic [ADDR_W-1:0] a1);
    @(posedge clka);
    #1;
    bus2.req0 = r0;
    bus2.addr0 = a0;
    bus2.req1 = r1;
    bus2.addr1 = a1;
  endtask

  task automatic idle2(input int n);
    for (int k = 0; k < n; k++) drive2(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic exp_g1;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i * 16'h0101 + 16'h1234);
    bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.addr0 = '0; bus1.addr1 = '0;
    // requests asserted during reset must not be granted
    bus2.req0 = 1'b1; bus2.req1 = 1'b1; bus2.addr0 = 13'h3; bus2.addr1 = 13'h4;
    rv0_run = 0; rv0_max = 0; rv0_total = 0;

    // reset state
    @(negedge clka);
    @(negedge clka);
    check("rst_gnt0", bus2.gnt0, 0);
    check("rst_gnt1", bus2.gnt1, 0);
    check("rst_ram_en", bus2.ram_en, 0);
    check("rst_regce", bus2.ram_regce, 0);
    check("rst_ram_addr", bus2.ram_addr, 0);
    check("rst_rvalid", {bus2.rvalid1, bus2.rvalid0}, 0);

    // single read on requester 1, granted in the first cycle out of reset
    drive2(1'b0, '0, 1'b1, 13'h0005);
    rsta_n = 1'b1;
    @(negedge clka);
    check("single_gnt1", bus2.gnt1, 1);
    check("single_gnt0", bus2.gnt0, 0);
    idle2(1);
    @(negedge clka);
    check("single_ram_en", bus2.ram_en, 1);
    check("single_ram_addr", bus2.ram_addr, 32'h5);
    check("single_rv_early", bus2.rvalid1, 0);
    @(negedge clka);
    check("single_regce", bus2.ram_regce, 1);
    check("single_en_drop", bus2.ram_en, 0);
    check("single_rv_early2", bus2.rvalid1, 0);
    @(negedge clka);
    check("single_rvalid1", bus2.rvalid1, 1);
    check("single_rdata", bus2.rdata, 32'h1739);
    @(negedge clka);
    check("single_rv_after", bus2.rvalid1, 0);

    // back-to-back on requester 0, addresses 0..7
    rv0_run = 0; rv0_max = 0; rv0_total = 0;
    for (int i = 0; i < 8; i++) begin
      drive2(1'b1, ADDR_W'(i), 1'b0, '0);
      @(negedge clka);
      check("b2b_gnt0", bus2.gnt0, 1);
    end
    idle2(5);
    check("b2b_rv0_total", rv0_total, 8);
    check("b2b_rv0_run", rv0_max, 8);

    // id alternation with no bubbles
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive2(1'b1, ADDR_W'(13'h100 + i), 1'b0, '0);
      else drive2(1'b0, '0, 1'b1, ADDR_W'(13'h100 + i));
      @(negedge clka);
      check("alt_gnt", {bus2.gnt1, bus2.gnt0}, (i % 2 == 0) ? 32'b01 : 32'b10);
      check("alt_ram_en", bus2.ram_en, (i == 0) ? 32'd0 : 32'd1);
    end
    idle2(5);

    // contention: both requesters held high
    for (int i = 0; i < 20; i++) begin
      drive2(1'b1, 13'h010, 1'b1, 13'h020);
      @(negedge clka);
`ifdef BRAM_ARB_STARVE_GUARD_EN
      exp_g1 = (i % 9 == 8);
`else
      exp_g1 = 1'b0;
`endif
      check("cont_gnt1", bus2.gnt1, {31'd0, exp_g1});
      check("cont_gnt0", bus2.gnt0, {31'd0, ~exp_g1});
    end
    idle2(5);

    // reset right after two accepted reads discards them
    drive2(1'b1, 13'h030, 1'b0, '0);
    @(negedge clka);
    check("flight_gnt0_a", bus2.gnt0, 1);
    drive2(1'b1, 13'h031, 1'b0, '0);
    @(negedge clka);
    check("flight_gnt0_b", bus2.gnt0, 1);
    @(posedge clka);
    #1;
    rsta_n = 1'b0;
    bus2.req0 = 1'b0;
    @(negedge clka);
    check("flight_rst_en", bus2.ram_en, 0);
    check("flight_rst_rv", {bus2.rvalid1, bus2.rvalid0}, 0);
    drive2(1'b0, '0, 1'b1, 13'h040);
    rsta_n = 1'b1;
    @(negedge clka);
    check("flight_regrant", bus2.gnt1, 1);
    idle2(1);
    @(negedge clka);
    check("flight_rv0_gone_a", bus2.rvalid0, 0);
    @(negedge clka);
    check("flight_rv0_gone_b", bus2.rvalid0, 0);
    @(negedge clka);
    check("flight_new_rvalid1", bus2.rvalid1, 1);
    check("flight_new_rdata", bus2.rdata, 32'h5274);
    @(negedge clka);
    check("flight_rv_after", {bus2.rvalid1, bus2.rvalid0}, 0);

    // LATENCY=1 instance: single read
    @(posedge clka);
    #1;
    bus1.req0 = 1'b1;
    bus1.addr0 = 13'h0007;
    @(negedge clka);
    check("l1_gnt0", bus1.gnt0, 1);
    check("l1_regce_a", bus1.ram_regce, 0);
    @(posedge clka);
    #1;
    bus1.req0 = 1'b0;
    @(negedge clka);
    check("l1_ram_en", bus1.ram_en, 1);
    check("l1_ram_addr", bus1.ram_addr, 32'h7);
    check("l1_rv_early", bus1.rvalid0, 0);
    check("l1_regce_b", bus1.ram_regce, 0);
    @(negedge clka);
    check("l1_rvalid0", bus1.rvalid0, 1);
    check("l1_rdata", bus1.rdata, 32'h193b);
    check("l1_regce_c", bus1.ram_regce, 0);
    @(negedge clka);
    check("l1_rv_after", bus1.rvalid0, 0);

    idle2(3);
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning RAM data width (RGB565 pixel).
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning RAM read latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL have parameter STARVE_MAX, default 7, meaning the number of denied cycles after which requester 1 is promoted.
REQ-005 The block SHALL have port clka, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rsta_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports req0 and req1, input, 1 bit each: read request from requester 0 (display scan) and requester 1 (sprite/aux).
REQ-008 The block SHALL have ports addr0 and addr1, input, ADDR_W bits each: request addresses.
REQ-009 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: combinational grant, meaning the request is accepted at this edge.
REQ-010 The block SHALL have ports rvalid0 and rvalid1, output, 1 bit each: rdata belongs to that requester in this cycle.
REQ-011 The block SHALL have port rdata, output, DATA_W bits: read data, a pass-through of ram_dout.
REQ-012 The block SHALL have ports ram_addr (ADDR_W), ram_en (1) and ram_regce (1), outputs, driving the RAM addra, ena and regcea pins.
REQ-013 The block SHALL have port ram_dout, input, DATA_W bits: the RAM douta.

Function
REQ-014 Requester handshake SHALL be: hold reqN high with addrN stable until gnt sampled high; the request is accepted at that edge.
REQ-015 At most one grant SHALL be high per cycle, and no grant SHALL be issued when neither req is high.
REQ-016 Default arbitration SHALL be fixed priority: req0 over req1.
REQ-017 On acceptance, ram_addr and ram_en SHALL register the granted address and 1 on the same edge; ram_en SHALL be 0 in every cycle without an issue.
REQ-018 A tag pipeline (valid and id) of LATENCY+1 stages SHALL track each issue; stage 0 is aligned with ram_en.
REQ-019 ram_regce SHALL equal stage-1 valid when LATENCY=2, and SHALL be held 0 when LATENCY=1.
REQ-020 rvalidN SHALL be high exactly when stage LATENCY is valid with id N, i.e. LATENCY+1 cycles after the accept edge.
REQ-021 rdata SHALL equal ram_dout in all cycles; rdata content is meaningful only while an rvalid is high.
REQ-022 Throughput SHALL be one accepted read per cycle with no bubbles, including on id alternation.
REQ-023 Returns SHALL be delivered in issue order, with at most LATENCY+1 reads in flight.
REQ-024 Simultaneous req0 and req1 SHALL grant one requester only; the loser holds its request and is served on a later cycle.

Reset
REQ-025 While rsta_n is low: gnt0/1=0, rvalid0/1=0, ram_en=0, ram_regce=0, ram_addr=0, all tag stages invalid, and the starve counter=0.
REQ-026 Reset asserted mid-transfer SHALL discard all in-flight reads; no rvalid SHALL appear for them after release.
REQ-027 The first grant after release SHALL be possible in the first cycle with rsta_n high.

Configuration
REQ-028 Macro BRAM_ARB_STARVE_GUARD_EN, when defined, SHALL add a saturating counter incremented each cycle req1 is high and not granted.
REQ-029 The counter SHALL clear on gnt1 or whenever req1 is low.
REQ-030 When the counter equals STARVE_MAX, req1 SHALL win the next arbitration over req0 for exactly one grant.
REQ-031 Without BRAM_ARB_STARVE_GUARD_EN, arbitration SHALL be strict req0 priority and no counter logic SHALL exist.

Verification
REQ-032 Single read: reset release, req1=1 with addr1=0x0005 for one accept -> gnt1 in that cycle; ram_en=1 and ram_addr=0x0005 in the next cycle; rvalid1=1 exactly 3 cycles after the accept edge (LATENCY=2); rdata equals the preloaded word.
REQ-033 Back-to-back: req0 held high for 8 cycles with addresses 0..7 -> 8 consecutive gnt0; rvalid0 high for 8 consecutive cycles with data in address order.
REQ-034 Contention without macro: req0 and req1 high for 20 cycles -> gnt0 every cycle and gnt1 never.
REQ-035 Contention with macro, STARVE_MAX=7: req0 and req1 high continuously -> gnt1 on every 9th cycle (8 gnt0 then 1 gnt1 repeating).
REQ-036 Reset mid-flight: two reads accepted, then rsta_n low one cycle later -> no rvalid for either read; a new read after release returns correctly.
REQ-037 LATENCY=1 build: single read -> rvalid 2 cycles after the accept edge; ram_regce stays 0.
